// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the RV32M multiply/divide unit and the
//               ID/EX decode logic: state encoding, funct3 codes, special-case
//               result constants and a conditional-negate helper.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int MD_XLEN = 32;

  // FSM state encoding (kept as plain constants for legacy decode compatibility)
  typedef logic [1:0] muldiv_state_t;
  localparam muldiv_state_t ST_IDLE = 2'd0;
  localparam muldiv_state_t ST_CALC = 2'd1;
  localparam muldiv_state_t ST_DONE = 2'd2;

  // M-extension funct3 codes
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [MD_XLEN-1:0] DIV_BY_ZERO_Q = {MD_XLEN{1'b1}};
  localparam logic [MD_XLEN-1:0] INT_MIN       = {1'b1, {(MD_XLEN-1){1'b0}}};

  // Two's-complement negate when neg is set; used both to take operand
  // magnitudes and to restore the sign of a quotient/remainder.
  function automatic logic [MD_XLEN-1:0] cond_neg(input logic [MD_XLEN-1:0] v,
                                                  input logic neg);
    return neg ? (~v + {{(MD_XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/execute_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : execute_muldiv
// Description : Iterative RV32M multiply/divide unit for the execute stage.
//               One radix-2 step per cycle (shift-add multiply, restoring
//               divide); divide-by-zero and signed overflow bypass iteration.
// Revision    : 1.0 - initial release
// Ports       : clk, reset      - clock, synchronous active-high reset
//               flush           - abort in-flight operation
//               start           - ID/EX holds a valid M-op
//               funct3          - M-op select
//               op_a, op_b      - rs1 / rs2 values after forwarding
//               rd_in           - destination register
//               stall           - freeze PC, IF/ID, ID/EX
//               done            - one-cycle pulse, result/rd_out valid
//               result, rd_out  - registered result and its destination
// ============================================================================
module execute_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  import muldiv_pkg::*;

  muldiv_state_t   state;
  logic [5:0]      count;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic            neg_q;
  // opnd: multiplicand (mul) or divisor (div).
  // hi:lo: product accumulator (mul) or remainder:dividend/quotient (div).
  logic [XLEN-1:0] opnd;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  // ---------------- accept-time decode ----------------
  logic            w_is_div, w_a_signed, w_b_signed, w_sa, w_sb, w_neg;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_special_val;
  logic            w_div_zero, w_overflow, w_special;

  assign w_is_div   = funct3[2];
  // Divide group: DIV/REM signed (funct3[0]=0). Multiply group: MULHU fully
  // unsigned, and op_b is signed only for MUL/MULH (funct3[1]=0).
  assign w_a_signed = w_is_div ? ~funct3[0] : (funct3 != F3_MULHU);
  assign w_b_signed = w_is_div ? ~funct3[0] : ~funct3[1];
  assign w_sa       = w_a_signed & op_a[XLEN-1];
  assign w_sb       = w_b_signed & op_b[XLEN-1];
  assign w_mag_a    = cond_neg(op_a, w_sa);
  assign w_mag_b    = cond_neg(op_b, w_sb);
  // Remainder follows the dividend; everything else follows sign(a)^sign(b).
  assign w_neg      = (w_is_div & funct3[1]) ? w_sa : (w_sa ^ w_sb);

  assign w_div_zero = w_is_div & (op_b == '0);
  assign w_overflow = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                      (op_a == INT_MIN) && (op_b == {XLEN{1'b1}});
  assign w_special  = w_div_zero | w_overflow;
  always_comb begin
    w_special_val = '0;
    if (w_div_zero) w_special_val = funct3[1] ? op_a : DIV_BY_ZERO_Q;
    else            w_special_val = funct3[1] ? '0 : INT_MIN;
  end

  // ---------------- iteration step ----------------
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shift, w_diff;
  logic              w_ge;
  logic [XLEN-1:0]   w_hi_n, w_lo_n;

  assign w_sum   = {1'b0, hi} + {1'b0, (lo[0] ? opnd : {XLEN{1'b0}})};
  assign w_shift = {hi, lo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, opnd};
  assign w_ge    = ~w_diff[XLEN];

  always_comb begin
    if (f3_q[2]) begin
      w_hi_n = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      w_lo_n = {lo[XLEN-2:0], w_ge};
    end else begin
      w_hi_n = w_sum[XLEN:1];
      w_lo_n = {w_sum[0], lo[XLEN-1:1]};
    end
  end

  // ---------------- sign fix-up and result select ----------------
  // Computed from the post-step values so the result register is loaded on the
  // edge into DONE and is already valid while done is high.
  logic [2*XLEN-1:0] w_prod, w_prod_fix;
  logic [XLEN-1:0]   w_final;

  assign w_prod     = {w_hi_n, w_lo_n};
  assign w_prod_fix = neg_q ? (~w_prod + {{(2*XLEN-1){1'b0}}, 1'b1}) : w_prod;

  always_comb begin
    w_final = '0;
    case (f3_q)
      F3_MUL:                   w_final = w_prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU,
      F3_MULHU:                 w_final = w_prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:          w_final = cond_neg(w_lo_n, neg_q);
      default:                  w_final = cond_neg(w_hi_n, neg_q);
    endcase
  end

  // ---------------- FSM / datapath registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      count  <= 6'd0;
      f3_q   <= 3'd0;
      rd_q   <= 5'd0;
      neg_q  <= 1'b0;
      opnd   <= '0;
      hi     <= '0;
      lo     <= '0;
      result <= '0;
      rd_out <= 5'd0;
    end else if (flush) begin
      state <= ST_IDLE;
      count <= 6'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            f3_q  <= funct3;
            rd_q  <= rd_in;
            neg_q <= w_neg;
            opnd  <= w_is_div ? w_mag_b : w_mag_a;
            hi    <= '0;
            lo    <= w_is_div ? w_mag_a : w_mag_b;
            count <= 6'd0;
            if (w_special) begin
              result <= w_special_val;
              rd_out <= rd_in;
              state  <= ST_DONE;
            end else begin
              state  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          hi <= w_hi_n;
          lo <= w_lo_n;
          if (count == 6'd31) begin
            count  <= 6'd0;
            result <= w_final;
            rd_out <= rd_q;
            state  <= ST_DONE;
          end else begin
            count  <= count + 6'd1;
          end
        end
        // start is still the finishing instruction here, so it is ignored.
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign stall = ~reset & ~flush &
                 (((state == ST_IDLE) & start) | (state == ST_CALC));
  assign done  = ~reset & ~flush & (state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_execute_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_muldiv
// Description : Self-checking bench for execute_muldiv: directed vector table
//               plus flush, reset-mid-operation and back-to-back sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        reset, flush, start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        stall, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_cmp = 0;
  int n_err = 0;

  execute_muldiv #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .start(start),
    .funct3(funct3), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .stall(stall), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Entered just after a rising edge; start is held until DONE ends, as the
  // frozen ID/EX register would do. Leaves just after the edge ending DONE.
  task automatic run_op(input vec_t v, input string nm);
    int cyc;
    bit seen;
    bit st_ok;
    funct3 = v.f3; op_a = v.a; op_b = v.b; rd_in = v.rd; start = 1'b1;
    cyc = 0; seen = 1'b0; st_ok = 1'b1;
    while (!seen && cyc < 45) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        if (!stall) st_ok = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({nm, "_latency"}, seen ? cyc : -1, v.lat);
    check({nm, "_stall_busy"}, {31'd0, st_ok}, 32'd1);
    check({nm, "_stall_done"}, {31'd0, stall}, 32'd0);
    check({nm, "_result"}, result, v.exp);
    check({nm, "_rd"}, {27'd0, rd_out}, {27'd0, v.rd});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev_res;
    logic [4:0]  prev_rd;
    int          n_done;

    //           f3      a             b             rd     expected      lat
    vecs[0]  = '{3'b000, 32'd7,        32'd6,        5'd1,  32'd42,       33};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000, 33};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 33};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 33};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 33};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 33};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        5'd7,  32'd14,       33};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        5'd8,  32'd2,        33};
    vecs[8]  = '{3'b100, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 1};
    vecs[9]  = '{3'b111, 32'd5,        32'd0,        5'd10, 32'd5,        1};
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1};
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000, 1};
    vecs[12] = '{3'b000, 32'hFFFFFFFD, 32'd5,        5'd13, 32'hFFFFFFF1, 33};
    vecs[13] = '{3'b001, 32'hFFFFFFFD, 32'd5,        5'd14, 32'hFFFFFFFF, 33};
    vecs[14] = '{3'b100, 32'd7,        32'hFFFFFFFE, 5'd15, 32'hFFFFFFFD, 33};
    vecs[15] = '{3'b110, 32'd7,        32'hFFFFFFFE, 5'd16, 32'd1,        33};
    vecs[16] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0,        33};
    vecs[17] = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 33};
    vecs[18] = '{3'b011, 32'h80000000, 32'd4,        5'd19, 32'd2,        33};
    vecs[19] = '{3'b010, 32'd2,        32'hFFFFFFFF, 5'd20, 32'd1,        33};
    vecs[20] = '{3'b100, 32'h80000000, 32'd1,        5'd21, 32'h80000000, 33};

    reset = 1'b1; flush = 1'b0; start = 1'b0;
    funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_stall",  {31'd0, stall}, 32'd0);
    check("reset_done",   {31'd0, done},  32'd0);
    check("reset_result", result,         32'd0);
    check("reset_rd",     {27'd0, rd_out}, 32'd0);
    @(posedge clk); #1;

    // Table vectors run back-to-back: each start lands the cycle after DONE.
    for (int i = 0; i < 21; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    @(negedge clk);
    check("b2b_single_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;

    // Flush at cycle 10 of a DIV.
    prev_res = result; prev_rd = rd_out;
    funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd25; start = 1'b1;
    for (int c = 0; c < 10; c++) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    check("flush_cycle_stall", {31'd0, stall}, 32'd0);
    check("flush_cycle_done",  {31'd0, done},  32'd0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("flush_idle_stall", {31'd0, stall}, 32'd0);
    check("flush_result",     result,          prev_res);
    check("flush_rd",         {27'd0, rd_out}, {27'd0, prev_rd});
    n_done = 0;
    for (int c = 0; c < 40; c++) begin @(posedge clk); #1; if (done) n_done++; end
    check("flush_no_done", n_done, 32'd0);
    run_op('{3'b000, 32'd3, 32'd3, 5'd26, 32'd9, 33}, "after_flush_mul");

    // Reset at cycle 20 of a MUL.
    funct3 = 3'b000; op_a = 32'd7; op_b = 32'd6; rd_in = 5'd27; start = 1'b1;
    for (int c = 0; c < 20; c++) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_mid_stall",  {31'd0, stall},  32'd0);
    check("rst_mid_done",   {31'd0, done},   32'd0);
    check("rst_mid_result", result,          32'd0);
    check("rst_mid_rd",     {27'd0, rd_out}, 32'd0);
    @(posedge clk); #1;
    run_op('{3'b101, 32'd100, 32'd7, 5'd28, 32'd14, 33}, "after_reset_divu");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/execute_muldiv.md
# execute_muldiv

Iterative RV32M multiply/divide unit in the execute stage, fed directly by the decode/execute pipeline register outputs (operands, funct3, rd). It accepts one M-extension operation at a time and computes it over multiple cycles. While busy, it holds the front of the pipeline via `stall`. It returns a registered result with `done` for the EX/MEM register to capture.

## Interface
- `XLEN`, default 32: operand/result width. The unit is only verified at 32.
- `clk`  in  1: clock
- `reset`  in  1: synchronous, active-high
- `flush`  in  1: abort any in-flight operation (branch taken / exception)
- `start`  in  1: ID/EX holds a valid M-op (opcode OP, funct7 = 0000001)
- `funct3`  in  3: M-op select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `op_a`  in  XLEN: rs1 value, after forwarding
- `op_b`  in  XLEN: rs2 value, after forwarding
- `rd_in`  in  5: destination register
- `stall`  out  1: freeze PC, IF/ID and ID/EX
- `done`  out  1: one-cycle pulse; `result`/`rd_out` valid
- `result`  out  XLEN: operation result, held until the next accept
- `rd_out`  out  5: destination register of `result`

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - `start`=1 accepts the operation.
  - Latches `funct3`, `rd_in`, the operand magnitudes and the result-sign flags.
  - Goes to CALC, or directly to DONE for special cases.
- **CALC**
  - Performs one radix-2 step per cycle; a 6-bit counter runs 0..31.
  - Multiply uses shift-add into a 64-bit product.
  - Divide uses restoring shift-subtract, producing a quotient and remainder.
  - After step 31, the FSM goes to DONE.
- **DONE**
  - Applies the sign fix-up, registers `result`, and pulses `done`.
  - Always returns to IDLE.
  - `start` is ignored in DONE, because it still reflects the finishing instruction.
- **Signedness**
  - MUL/MULH/DIV/REM treat both operands as signed.
  - MULHSU: `op_a` signed, `op_b` unsigned.
  - MULHU/DIVU/REMU treat both operands as unsigned.
  - Operands are converted to magnitudes, and the result is negated at the end if required.
- **Result selection**
  - MUL returns product[31:0]; the MULH variants return product[63:32].
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
  - The remainder takes the sign of the dividend.
- **Special cases** (resolved in IDLE, bypass CALC):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return `op_a`.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000, REM returns 0.
- All arithmetic is modulo 2^XLEN. There are no exceptions or flags.

## Timing
- **Reset** (synchronous, overrides everything): state = IDLE, counter = 0, and `stall`, `done`, `result`, `rd_out` are all 0.
- **Latency**
  - Accept happens at cycle 0.
  - For normal operations, CALC spans cycles 1..32 and DONE is cycle 33.
  - For special cases, DONE is cycle 1.
- **`stall`**
  - Combinational: equals (IDLE & `start`) | CALC.
  - It is 0 in DONE, so ID/EX advances at the end of the DONE cycle.
- **`done`**: high only in DONE, for exactly one cycle per accepted operation.
- **`flush`**
  - In any state, it forces IDLE on the next edge.
  - In that cycle `done` = 0 and `stall` = 0; `result` and `rd_out` keep their previous values.
  - `flush` together with `start` in IDLE means no accept.
- **Back-to-back**: a new `start` seen in IDLE on the cycle after DONE is accepted normally. Inter-op throughput is therefore 34 cycles.
- **Counter**: wraps 31→0 on CALC exit. No other wrap occurs.

## Structure
- Package `muldiv_pkg` holds:
  - the state enum;
  - localparams for the eight funct3 codes;
  - the constants `DIV_BY_ZERO_Q` = all-ones and `INT_MIN` = 1<<(XLEN-1);
  - an `abs`/negate helper function.
- No sub-module: datapath and FSM live in `execute_muldiv`. The package is shared with the ID/EX decode logic.

## Test plan
- **MUL**: `op_a`=7, `op_b`=6, funct3=000.
  - Expect `stall` high for cycles 0–32, `done` at cycle 33, `result`=42.
  - `rd_out` equals the latched `rd_in`.
- **MULH / MULHU**: `op_a`=0xFFFFFFFF, `op_b`=0xFFFFFFFF.
  - MULH (001) gives 0x00000000 and MULHU (011) gives 0xFFFFFFFE.
  - MULHSU (010) with the same operands gives 0xFFFFFFFF.
- **DIV / REM**: `op_a`=-7, `op_b`=2.
  - DIV gives 0xFFFFFFFD (-3) and REM gives 0xFFFFFFFF (-1).
  - DIVU with `op_a`=100, `op_b`=7 gives 14; REMU gives 2.
- **Special cases**, each with `done` at cycle 1:
  - DIV x/0 with `op_a`=5 gives 0xFFFFFFFF.
  - REMU 5/0 gives 5.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM with the same operands gives 0.
- **Flush**: assert `flush` at cycle 10 of a DIV.
  - Next cycle the unit is IDLE with `stall`=0, no `done` follows, and `result` is unchanged.
  - A new MUL 3×3 started afterwards returns 9.
- **Reset mid-CALC**: assert `reset` at cycle 20.
  - Next cycle all outputs are 0, and `start` is honoured on the following cycle.
  - Also check back-to-back ops: the second `start` is accepted the cycle after DONE, with exactly one `done` per op.
